// File: rtl/stripe_engine.sv
// Tagged-operand vector engine: captures A/B lane vectors from a broadcast bus,
// runs add/sub/mul/mac per iteration and drains one saturated result vector.
module stripe_engine #(
  parameter int LANES = 8,
  parameter int IN_W  = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 32,
  parameter int TAG_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [1:0]              cfg_op,
  input  logic                    cfg_accum,
  input  logic [TAG_W-1:0]        cfg_tag_a,
  input  logic [TAG_W-1:0]        cfg_tag_b,
  input  logic [TAG_W-1:0]        cfg_stride_a,
  input  logic [TAG_W-1:0]        cfg_stride_b,
  input  logic [TAG_W-1:0]        cfg_iter_lim,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic [LANES*IN_W-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*IN_W-1:0]   out_data,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EXEC, S_DRAIN} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b11;

  localparam logic signed [ACC_W-1:0] ONE     = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] RND     = ONE <<< (FRAC-1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = (ONE <<< (IN_W-1)) - ONE;
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic [TAG_W-1:0]        CNT_ONE = {{(TAG_W-1){1'b0}}, 1'b1};

  // Input carries one guard bit; overflow shows as disagreeing top two bits.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic [ACC_W:0] v);
    if (v[ACC_W] != v[ACC_W-1])
      sat_acc = v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_acc = v[ACC_W-1:0];
  endfunction

  function automatic logic [IN_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    if (v > OUT_MAX)
      sat_out = {1'b0, {(IN_W-1){1'b1}}};
    else if (v < OUT_MIN)
      sat_out = {1'b1, {(IN_W-1){1'b0}}};
    else
      sat_out = v[IN_W-1:0];
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_op;
  logic             r_accum;
  logic [TAG_W-1:0] r_tag_a;
  logic [TAG_W-1:0] r_tag_b;
  logic [TAG_W-1:0] r_stride_a;
  logic [TAG_W-1:0] r_stride_b;
  logic [TAG_W-1:0] r_iter_lim;
  logic [TAG_W-1:0] r_iter_cnt;
  logic             r_got_a;
  logic             r_got_b;

  logic             w_cfg_take;
  logic             w_beat;
  logic             w_hit_a;
  logic             w_hit_b;
  logic [TAG_W-1:0] w_cnt_nxt;

  assign w_cfg_take = cfg_valid && (r_state == S_IDLE);
  assign w_beat     = in_valid && (r_state == S_COLLECT);
  assign w_hit_a    = w_beat && (in_tag == r_tag_a) && !r_got_a;
  assign w_hit_b    = w_beat && (in_tag == r_tag_b) && !r_got_b;
  assign w_cnt_nxt  = r_iter_cnt + CNT_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (cfg_valid)
                   w_state_nxt = (cfg_iter_lim == '0) ? S_DRAIN : S_COLLECT;
      S_COLLECT: if ((r_got_a || w_hit_a) && (r_got_b || w_hit_b))
                   w_state_nxt = S_EXEC;
      S_EXEC:    w_state_nxt = (w_cnt_nxt == r_iter_lim) ? S_DRAIN : S_COLLECT;
      S_DRAIN:   if (out_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (r_state == S_IDLE);
    in_ready  = (r_state == S_COLLECT);
    out_valid = (r_state == S_DRAIN);
    busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op       <= '0;
      r_accum    <= 1'b0;
      r_tag_a    <= '0;
      r_tag_b    <= '0;
      r_stride_a <= '0;
      r_stride_b <= '0;
      r_iter_lim <= '0;
      r_iter_cnt <= '0;
      r_got_a    <= 1'b0;
      r_got_b    <= 1'b0;
    end else begin
      if (w_cfg_take) begin
        r_op       <= cfg_op;
        r_accum    <= cfg_accum || (cfg_op == OP_MAC);
        r_tag_a    <= cfg_tag_a;
        r_tag_b    <= cfg_tag_b;
        r_stride_a <= cfg_stride_a;
        r_stride_b <= cfg_stride_b;
        r_iter_lim <= cfg_iter_lim;
        r_iter_cnt <= '0;
        r_got_a    <= 1'b0;
        r_got_b    <= 1'b0;
      end
      if (w_hit_a) r_got_a <= 1'b1;
      if (w_hit_b) r_got_b <= 1'b1;
      // Tags advance modulo 2^TAG_W, so 0xFFF + 1 wraps back to tag 0.
      if (r_state == S_EXEC) begin
        r_tag_a    <= r_tag_a + r_stride_a;
        r_tag_b    <= r_tag_b + r_stride_b;
        r_iter_cnt <= w_cnt_nxt;
        r_got_a    <= 1'b0;
        r_got_b    <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [IN_W-1:0]  r_a;
    logic signed [IN_W-1:0]  r_b;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_a_ext;
    logic signed [ACC_W-1:0] w_b_ext;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_r;
    logic        [ACC_W:0]   w_sum;

    assign w_a_ext = {{(ACC_W-IN_W){r_a[IN_W-1]}}, r_a};
    assign w_b_ext = {{(ACC_W-IN_W){r_b[IN_W-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_comb begin
      case (r_op)
        OP_ADD:  w_r = w_a_ext + w_b_ext;
        OP_SUB:  w_r = w_a_ext - w_b_ext;
        default: w_r = (w_prod + RND) >>> FRAC;
      endcase
    end

    assign w_sum = r_accum ? ({r_acc[ACC_W-1], r_acc} + {w_r[ACC_W-1], w_r})
                           : {w_r[ACC_W-1], w_r};

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_a   <= '0;
        r_b   <= '0;
        r_acc <= '0;
      end else begin
        if (w_hit_a) r_a <= in_data[i*IN_W +: IN_W];
        if (w_hit_b) r_b <= in_data[i*IN_W +: IN_W];
        if (w_cfg_take)             r_acc <= '0;
        else if (r_state == S_EXEC) r_acc <= sat_acc(w_sum);
      end
    end

    assign out_data[i*IN_W +: IN_W] = (r_state == S_DRAIN) ? sat_out(r_acc) : '0;
  end

endmodule

// File: tb/tb_stripe_engine.sv
// Directed bench for stripe_engine: stimulus pushes hand-computed result
// vectors into a scoreboard; a monitor pops them on each accepted output beat.
module tb_stripe_engine;

  localparam int LANES = 8;
  localparam int IN_W  = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 32;
  localparam int TAG_W = 12;
  localparam int DW    = LANES * IN_W;

  logic             clk;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_op;
  logic             cfg_accum;
  logic [TAG_W-1:0] cfg_tag_a;
  logic [TAG_W-1:0] cfg_tag_b;
  logic [TAG_W-1:0] cfg_stride_a;
  logic [TAG_W-1:0] cfg_stride_b;
  logic [TAG_W-1:0] cfg_iter_lim;
  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             busy;

  stripe_engine #(
    .LANES(LANES), .IN_W(IN_W), .FRAC(FRAC), .ACC_W(ACC_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op), .cfg_accum(cfg_accum),
    .cfg_tag_a(cfg_tag_a), .cfg_tag_b(cfg_tag_b),
    .cfg_stride_a(cfg_stride_a), .cfg_stride_b(cfg_stride_b), .cfg_iter_lim(cfg_iter_lim),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [DW-1:0] exp_q[$];
  string         name_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [15:0] l0, input logic [15:0] l1);
    logic [DW-1:0] v;
    v = '0;
    v[15:0]  = l0;
    v[31:16] = l1;
    return v;
  endfunction

  task automatic expect_out(input string name, input logic [DW-1:0] v);
    name_q.push_back(name);
    exp_q.push_back(v);
  endtask

  // Monitor: every accepted output beat is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected no beat", out_data);
      end else begin
        chk(name_q.pop_front(), out_data, exp_q.pop_front());
      end
    end
  end

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, expected handshake", name);
  endtask

  task automatic cfg(input logic [1:0] op, input logic acc,
                     input logic [TAG_W-1:0] ta, input logic [TAG_W-1:0] sa,
                     input logic [TAG_W-1:0] tb, input logic [TAG_W-1:0] sb,
                     input logic [TAG_W-1:0] lim);
    int n = 0;
    while (!cfg_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (!cfg_ready) timeout("cfg_wait");
    cfg_op = op; cfg_accum = acc; cfg_tag_a = ta; cfg_stride_a = sa;
    cfg_tag_b = tb; cfg_stride_b = sb; cfg_iter_lim = lim; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic beat(input logic [TAG_W-1:0] tag, input logic [DW-1:0] data);
    int n = 0;
    while (!in_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (!in_ready) timeout("in_wait");
    in_tag = tag; in_data = data; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy && n < 500) begin @(posedge clk); #1; n++; end
    if (busy) timeout("done_wait");
  endtask

  task automatic mac_run();
    beat(12'h010, mk(16'h0100, 16'h0)); beat(12'h100, mk(16'h0200, 16'h0));
    beat(12'h011, mk(16'h0100, 16'h0)); beat(12'h102, mk(16'h0200, 16'h0));
    beat(12'h012, mk(16'h0100, 16'h0)); beat(12'h104, mk(16'h0200, 16'h0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_op = '0; cfg_accum = 1'b0;
    cfg_tag_a = '0; cfg_tag_b = '0; cfg_stride_a = '0; cfg_stride_b = '0;
    cfg_iter_lim = '0; in_valid = 1'b0; in_tag = '0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, '0);
    rst = 1'b1;
    @(posedge clk); #1;

    // MAC over three iterations with back-pressure on the result.
    expect_out("mac", mk(16'h0600, 16'h0));
    out_ready = 1'b0;
    cfg(2'b11, 1'b0, 12'h010, 12'h001, 12'h100, 12'h002, 12'd3);
    mac_run();
    chk("exec_no_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("drain_valid", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, mk(16'h0600, 16'h0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done();

    // Positive saturation over two accumulated adds, then negative on sub.
    expect_out("sat_add", mk(16'h7FFF, 16'h0));
    cfg(2'b00, 1'b1, 12'h001, 12'h000, 12'h002, 12'h000, 12'd2);
    beat(12'h001, mk(16'h7F00, 16'h0)); beat(12'h002, mk(16'h7F00, 16'h0));
    beat(12'h001, mk(16'h7F00, 16'h0)); beat(12'h002, mk(16'h7F00, 16'h0));
    wait_done();
    expect_out("sat_sub", mk(16'h8000, 16'h0));
    cfg(2'b01, 1'b0, 12'h001, 12'h000, 12'h002, 12'h000, 12'd1);
    beat(12'h001, mk(16'h8000, 16'h0)); beat(12'h002, mk(16'h0100, 16'h0));
    wait_done();

    // Rounding of the fixed-point product (lane1: 2.0 * 1.5 = 3.0).
    expect_out("rnd_pos", mk(16'h0001, 16'h0300));
    cfg(2'b10, 1'b0, 12'h003, 12'h000, 12'h004, 12'h000, 12'd1);
    beat(12'h003, mk(16'h0001, 16'h0200)); beat(12'h004, mk(16'h0080, 16'h0180));
    wait_done();
    expect_out("rnd_neg", mk(16'h0000, 16'h0));
    cfg(2'b10, 1'b0, 12'h003, 12'h000, 12'h004, 12'h000, 12'd1);
    beat(12'h003, mk(16'hFFFF, 16'h0)); beat(12'h004, mk(16'h0080, 16'h0));
    wait_done();

    // One beat feeds both operands when the tags coincide.
    expect_out("same_tag", mk(16'h0060, 16'h0));
    cfg(2'b00, 1'b1, 12'h005, 12'h000, 12'h005, 12'h000, 12'd2);
    beat(12'h005, mk(16'h0010, 16'h0));
    beat(12'h005, mk(16'h0020, 16'h0));
    wait_done();

    // First capture wins, stray tags dropped, config offered mid-run ignored.
    expect_out("dup_tag", mk(16'h0105, 16'h0));
    cfg(2'b00, 1'b0, 12'h020, 12'h001, 12'h030, 12'h001, 12'd1);
    cfg_op = 2'b01; cfg_iter_lim = 12'd0; cfg_valid = 1'b1;
    beat(12'h020, mk(16'h0100, 16'h0));
    chk("cfg_blocked", cfg_ready, 0);
    chk("busy_collect", busy, 1);
    beat(12'h020, mk(16'h0300, 16'h0));
    beat(12'h999, mk(16'h7777, 16'h0));
    cfg_valid = 1'b0;
    beat(12'h030, mk(16'h0005, 16'h0));
    wait_done();

    // Tag counter wraps from 0xFFF to 0x000.
    expect_out("tag_wrap", mk(16'h000F, 16'h0));
    cfg(2'b00, 1'b1, 12'hFFF, 12'h001, 12'h001, 12'h001, 12'd2);
    beat(12'hFFF, mk(16'h0001, 16'h0)); beat(12'h001, mk(16'h0002, 16'h0));
    beat(12'hFFF, mk(16'h0100, 16'h0));
    beat(12'h000, mk(16'h0004, 16'h0)); beat(12'h002, mk(16'h0008, 16'h0));
    wait_done();

    // Zero iterations go straight to an all-zero result.
    expect_out("zero_iter", '0);
    cfg(2'b00, 1'b0, 12'h000, 12'h000, 12'h000, 12'h000, 12'd0);
    chk("zero_valid", out_valid, 1);
    wait_done();

    // Asynchronous abort mid-run, then a clean rerun.
    cfg(2'b11, 1'b0, 12'h010, 12'h001, 12'h100, 12'h002, 12'd3);
    beat(12'h010, mk(16'h0100, 16'h0)); beat(12'h100, mk(16'h0200, 16'h0));
    beat(12'h011, mk(16'h0100, 16'h0));
    #2 rst = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cfg_ready", cfg_ready, 1);
    chk("abort_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    expect_out("mac_after_rst", mk(16'h0600, 16'h0));
    cfg(2'b11, 1'b0, 12'h010, 12'h001, 12'h100, 12'h002, 12'd3);
    mac_run();
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
